// File: rtl/kmeans_update_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : kmeans_update_ctrl_if
// Description : Point-stream and distance-engine bus of the K-means iteration
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface kmeans_update_ctrl_if #(
    parameter int DW       = 8,
    parameter int CLUSTERS = 2,
    parameter int PARAMS   = 13
);
    localparam int c_kw = (CLUSTERS > 1) ? $clog2(CLUSTERS) : 1;

    logic [PARAMS*DW-1:0]          pt_data_i;
    logic                          pt_valid_i;
    logic                          pt_ready_o;
    logic                          km_enable_o;
    logic [PARAMS*DW-1:0]          km_data_o;
    logic                          km_data_valid_o;
    logic [CLUSTERS*PARAMS*DW-1:0] km_centroid_o;
    logic                          km_centroid_valid_o;
    logic [c_kw-1:0]               km_cluster_i;
    logic                          km_valid_i;

    // Controller side
    modport master (
        input  pt_data_i, pt_valid_i, km_cluster_i, km_valid_i,
        output pt_ready_o, km_enable_o, km_data_o, km_data_valid_o,
               km_centroid_o, km_centroid_valid_o
    );

    // Point source / distance engine side
    modport slave (
        output pt_data_i, pt_valid_i, km_cluster_i, km_valid_i,
        input  pt_ready_o, km_enable_o, km_data_o, km_data_valid_o,
               km_centroid_o, km_centroid_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/kmeans_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kmeans_update_ctrl
// Description : K-means epoch controller: streams points to the distance
//               engine, accumulates per-cluster sums and recomputes centroids.
// Revision    : 1.0 - initial release
// ============================================================================
module kmeans_update_ctrl #(
    parameter int DW         = 8,
    parameter int CLUSTERS   = 2,
    parameter int PARAMS     = 13,
    parameter int MAX_POINTS = 256,
    parameter int MAX_ITERS  = 16,
    localparam int c_cw      = $clog2(MAX_POINTS + 1),
    localparam int c_iw      = $clog2(MAX_ITERS + 1)
) (
    input  wire                           clk_i,
    input  wire                           reset_i,
    input  wire                           start_i,
    input  wire [c_cw-1:0]                num_points_i,
    input  wire [CLUSTERS*PARAMS*DW-1:0]  init_centroid_i,
    kmeans_update_ctrl_if.master          bus,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          converged_o,
    output logic [c_iw-1:0]               iter_o
);
    localparam int c_sw   = DW + $clog2(MAX_POINTS);
    localparam int c_ne   = CLUSTERS * PARAMS;
    localparam int c_ew   = (c_ne > 1) ? $clog2(c_ne) : 1;
    localparam int c_cxw  = (CLUSTERS > 1) ? $clog2(CLUSTERS) : 1;
    localparam int c_pxw  = (PARAMS > 1) ? $clog2(PARAMS) : 1;
    localparam int c_dcw  = $clog2(c_sw + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FETCH  = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_UPDATE = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                r_state;
    logic [c_cw-1:0]       r_num_points;
    logic [c_cw-1:0]       r_pt_cnt;
    logic [c_cw-1:0]       r_count [CLUSTERS];
    logic [c_sw-1:0]       r_sum   [c_ne];
    logic [c_ne*DW-1:0]    r_cent;
    logic [c_ne*DW-1:0]    r_shadow;
    logic [PARAMS*DW-1:0]  r_km_data;
    logic [c_cxw-1:0]      r_c;
    logic [c_pxw-1:0]      r_p;
    logic                  r_changed;
    logic                  r_commit;
    logic                  r_div_active;
    logic [c_dcw-1:0]      r_div_cnt;
    logic [c_cw-1:0]       r_rem;
    logic [c_sw-1:0]       r_aq;
    logic                  r_pt_ready;
    logic                  r_km_enable;
    logic                  r_km_data_valid;
    logic                  r_cent_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_converged;
    logic [c_iw-1:0]       r_iter;

    logic [c_ew-1:0]       w_elem;
    logic [c_cw-1:0]       w_cnt;
    logic [DW-1:0]         w_old;
    logic [c_cw-1:0]       w_rem_in;
    logic [c_sw-1:0]       w_aq_in;
    logic [c_dcw-1:0]      w_step;
    logic [c_cw:0]         w_trial;
    logic                  w_ge;
    logic [c_cw-1:0]       w_rem_nx;
    logic [c_sw-1:0]       w_aq_nx;
    logic                  w_elem_done;
    logic                  w_elem_last;
    logic [DW-1:0]         w_new;
    logic [c_cw-1:0]       w_pt_cnt_nx;
    logic [c_iw-1:0]       w_iter_nx;

    // Restoring divider step: dividend and quotient share one shift register,
    // the first step of each element reads the sum directly so an element
    // with a nonzero count takes exactly c_sw cycles.
    always_comb begin
        w_elem      = c_ew'(r_c) * c_ew'(PARAMS) + c_ew'(r_p);
        w_cnt       = r_count[r_c];
        w_old       = r_cent[int'(w_elem)*DW +: DW];
        w_rem_in    = r_div_active ? r_rem : '0;
        w_aq_in     = r_div_active ? r_aq : r_sum[w_elem];
        w_step      = r_div_active ? r_div_cnt : '0;
        w_trial     = {w_rem_in, w_aq_in[c_sw-1]};
        w_ge        = (w_trial >= {1'b0, w_cnt});
        w_rem_nx    = w_ge ? c_cw'(w_trial - {1'b0, w_cnt}) : c_cw'(w_trial);
        w_aq_nx     = {w_aq_in[c_sw-2:0], w_ge};
        w_elem_done = (w_cnt == '0) || (w_step == c_dcw'(c_sw - 1));
        w_elem_last = (r_c == c_cxw'(CLUSTERS - 1)) && (r_p == c_pxw'(PARAMS - 1));
        w_new       = (w_cnt == '0) ? w_old : w_aq_nx[DW-1:0];
        w_pt_cnt_nx = r_pt_cnt + 1'b1;
        w_iter_nx   = r_iter + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state         <= S_IDLE;
            r_num_points    <= '0;
            r_pt_cnt        <= '0;
            for (int c = 0; c < CLUSTERS; c++) r_count[c] <= '0;
            for (int e = 0; e < c_ne; e++)     r_sum[e]   <= '0;
            r_cent          <= '0;
            r_shadow        <= '0;
            r_km_data       <= '0;
            r_c             <= '0;
            r_p             <= '0;
            r_changed       <= 1'b0;
            r_commit        <= 1'b0;
            r_div_active    <= 1'b0;
            r_div_cnt       <= '0;
            r_rem           <= '0;
            r_aq            <= '0;
            r_pt_ready      <= 1'b0;
            r_km_enable     <= 1'b0;
            r_km_data_valid <= 1'b0;
            r_cent_valid    <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_converged     <= 1'b0;
            r_iter          <= '0;
        end else begin
            r_km_enable  <= 1'b0;
            r_cent_valid <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_num_points <= num_points_i;
                        r_cent       <= init_centroid_i;
                        r_cent_valid <= 1'b1;
                        r_iter       <= '0;
                        r_converged  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_pt_cnt <= '0;
                    for (int c = 0; c < CLUSTERS; c++) r_count[c] <= '0;
                    for (int e = 0; e < c_ne; e++)     r_sum[e]   <= '0;
                    if (r_num_points == '0) begin
                        r_converged <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_pt_ready  <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.pt_valid_i) begin
                        r_km_data       <= bus.pt_data_i;
                        r_pt_ready      <= 1'b0;
                        r_km_enable     <= 1'b1;
                        r_km_data_valid <= 1'b1;
                        r_state         <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.km_valid_i) begin
                        for (int p = 0; p < PARAMS; p++) begin
                            r_sum[int'(bus.km_cluster_i)*PARAMS + p] <=
                                r_sum[int'(bus.km_cluster_i)*PARAMS + p] +
                                c_sw'(r_km_data[p*DW +: DW]);
                        end
                        r_count[bus.km_cluster_i] <= r_count[bus.km_cluster_i] + 1'b1;
                        r_pt_cnt        <= w_pt_cnt_nx;
                        r_km_data_valid <= 1'b0;
                        if (w_pt_cnt_nx == r_num_points) begin
                            r_c          <= '0;
                            r_p          <= '0;
                            r_changed    <= 1'b0;
                            r_commit     <= 1'b0;
                            r_div_active <= 1'b0;
                            r_state      <= S_UPDATE;
                        end else begin
                            r_pt_ready   <= 1'b1;
                            r_state      <= S_FETCH;
                        end
                    end
                end
                S_UPDATE: begin
                    if (r_commit) begin
                        r_commit     <= 1'b0;
                        r_cent       <= r_shadow;
                        r_cent_valid <= 1'b1;
                        r_iter       <= w_iter_nx;
                        r_pt_cnt     <= '0;
                        for (int c = 0; c < CLUSTERS; c++) r_count[c] <= '0;
                        for (int e = 0; e < c_ne; e++)     r_sum[e]   <= '0;
                        if (!r_changed) begin
                            r_converged <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_iter_nx == c_iw'(MAX_ITERS)) begin
                            r_converged <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_pt_ready  <= 1'b1;
                            r_state     <= S_FETCH;
                        end
                    end else if (w_elem_done) begin
                        r_shadow[int'(w_elem)*DW +: DW] <= w_new;
                        if (w_new != w_old) r_changed <= 1'b1;
                        r_div_active <= 1'b0;
                        if (w_elem_last) begin
                            r_commit <= 1'b1;
                        end else if (r_p == c_pxw'(PARAMS - 1)) begin
                            r_p <= '0;
                            r_c <= r_c + 1'b1;
                        end else begin
                            r_p <= r_p + 1'b1;
                        end
                    end else begin
                        r_div_active <= 1'b1;
                        r_div_cnt    <= w_step + 1'b1;
                        r_rem        <= w_rem_nx;
                        r_aq         <= w_aq_nx;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pt_ready_o          = r_pt_ready;
    assign bus.km_enable_o         = r_km_enable;
    assign bus.km_data_o           = r_km_data;
    assign bus.km_data_valid_o     = r_km_data_valid;
    assign bus.km_centroid_o       = r_cent;
    assign bus.km_centroid_valid_o = r_cent_valid;
    assign busy_o                  = r_busy;
    assign done_o                  = r_done;
    assign converged_o             = r_converged;
    assign iter_o                  = r_iter;
endmodule
`default_nettype wire

// File: tb/tb_kmeans_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kmeans_update_ctrl
// Description : Directed bench; instance 0 uses MAX_ITERS=16, instance 1
//               MAX_ITERS=1, both driven from the same start/centroid inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kmeans_update_ctrl;
    localparam int DW  = 8;
    localparam int CL  = 2;
    localparam int PR  = 2;
    localparam int MP  = 256;
    localparam int PW  = PR * DW;
    localparam int CTW = CL * PW;
    localparam int CW  = $clog2(MP + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [CW-1:0]  num_points = '0;
    logic [CTW-1:0] init_c = '0;
    logic [PW-1:0]  pts [4];
    int             np = 0;
    bit             gaps = 1'b0;
    int             errors = 0;
    int             checks = 0;

    logic [CTW-1:0] res_cent [2];
    int             res_iter [2];
    int             res_conv [2];
    int             res_cyc  [2];

    always #5 clk = ~clk;

    function automatic logic nearest(input logic [PW-1:0] pt, input logic [CTW-1:0] cs);
        int   best = -1;
        logic k = 1'b0;
        for (int c = 0; c < CL; c++) begin
            int d = 0;
            for (int p = 0; p < PR; p++) begin
                int df = int'(pt[p*DW +: DW]) - int'(cs[(c*PR + p)*DW +: DW]);
                d += df * df;
            end
            if (best < 0 || d < best) begin
                best = d;
                k    = c[0];
            end
        end
        return k;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int MI  = (g == 0) ? 16 : 1;
        localparam int IWG = $clog2(MI + 1);

        kmeans_update_ctrl_if #(.DW(DW), .CLUSTERS(CL), .PARAMS(PR)) bus ();
        logic           busy, done, conv;
        logic [IWG-1:0] iter;
        int             idx = 0, en_cnt = 0, cv_cnt = 0, unstable = 0, eng_cd = 0;
        logic [PW-1:0]  eng_pt = '0;

        kmeans_update_ctrl #(
            .DW(DW), .CLUSTERS(CL), .PARAMS(PR), .MAX_POINTS(MP), .MAX_ITERS(MI)
        ) dut (
            .clk_i           (clk),
            .reset_i         (rst),
            .start_i         (start),
            .num_points_i    (num_points),
            .init_centroid_i (init_c),
            .bus             (bus),
            .busy_o          (busy),
            .done_o          (done),
            .converged_o     (conv),
            .iter_o          (iter)
        );

        // Point source replaying pts[0..np-1] each epoch
        always @(posedge clk) begin
            if (rst || (start && !busy)) idx <= 0;
            else if (bus.pt_valid_i && bus.pt_ready_o) idx <= (idx + 1 == np) ? 0 : idx + 1;
        end
        always @(negedge clk) begin
            bus.pt_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.pt_data_i  = pts[idx];
        end

        // Five-cycle nearest-centroid engine
        always @(posedge clk) begin
            if (rst) begin
                eng_cd          <= 0;
                bus.km_valid_i  <= 1'b0;
                bus.km_cluster_i <= '0;
            end else begin
                bus.km_valid_i <= 1'b0;
                if (bus.km_enable_o) begin
                    eng_pt           <= bus.km_data_o;
                    bus.km_cluster_i <= nearest(bus.km_data_o, bus.km_centroid_o);
                    eng_cd           <= 4;
                end else if (eng_cd > 0) begin
                    eng_cd <= eng_cd - 1;
                    if (eng_cd == 1) bus.km_valid_i <= 1'b1;
                end
            end
        end

        always @(posedge clk) begin
            if (start && !busy && !rst) begin
                en_cnt   <= 0;
                cv_cnt   <= 0;
                unstable <= 0;
            end else begin
                if (bus.km_enable_o) en_cnt <= en_cnt + 1;
                if (bus.km_centroid_valid_o) cv_cnt <= cv_cnt + 1;
                if (bus.km_data_valid_o && !bus.km_enable_o && bus.km_data_o !== eng_pt)
                    unstable <= unstable + 1;
            end
        end
    end

    task automatic load_scn1();
        init_c = {8'd12, 8'd12, 8'd0, 8'd0};
        pts[0] = {8'd0, 8'd0};   pts[1] = {8'd2, 8'd2};
        pts[2] = {8'd10, 8'd10}; pts[3] = {8'd12, 8'd12};
        np = 4;
    endtask

    task automatic run(input int n, input bit busy_start);
        num_points = CW'(n);
        res_cyc[0] = -1;
        res_cyc[1] = -1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            if (g_inst[0].done && res_cyc[0] < 0) begin
                res_cyc[0]  = cyc;
                res_cent[0] = g_inst[0].bus.km_centroid_o;
                res_iter[0] = int'(g_inst[0].iter);
                res_conv[0] = int'(g_inst[0].conv);
            end
            if (g_inst[1].done && res_cyc[1] < 0) begin
                res_cyc[1]  = cyc;
                res_cent[1] = g_inst[1].bus.km_centroid_o;
                res_iter[1] = int'(g_inst[1].iter);
                res_conv[1] = int'(g_inst[1].conv);
            end
            if (res_cyc[0] >= 0 && res_cyc[1] >= 0) break;
            if (busy_start && cyc == 20) begin
                start      = 1'b1;
                num_points = '0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (res_cyc[i] < 0) begin
                checks++;
                errors++;
                $display("FAIL timeout inst%0d: done_o never seen, required within 3000 cycles", i);
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_reset(input string tag);
        checks++;
        if ({g_inst[0].bus.pt_ready_o, g_inst[0].bus.km_enable_o, g_inst[0].bus.km_data_valid_o,
             g_inst[0].bus.km_centroid_valid_o, g_inst[0].busy, g_inst[0].done, g_inst[0].conv,
             g_inst[1].busy, g_inst[1].done, g_inst[1].conv} !== 10'b0) begin
            errors++;
            $display("FAIL %s flags: got %b%b%b%b%b%b%b required 0000000", tag,
                     g_inst[0].bus.pt_ready_o, g_inst[0].bus.km_enable_o, g_inst[0].bus.km_data_valid_o,
                     g_inst[0].bus.km_centroid_valid_o, g_inst[0].busy, g_inst[0].done, g_inst[0].conv);
        end
        checks++;
        if (g_inst[0].iter !== '0 || g_inst[1].iter !== '0) begin
            errors++;
            $display("FAIL %s iter: got %0d/%0d required 0", tag, g_inst[0].iter, g_inst[1].iter);
        end
        checks++;
        if (g_inst[0].bus.km_data_o !== '0 || g_inst[0].bus.km_centroid_o !== '0 ||
            g_inst[1].bus.km_centroid_o !== '0) begin
            errors++;
            $display("FAIL %s data: got km_data=%h centroid=%h required 0", tag,
                     g_inst[0].bus.km_data_o, g_inst[0].bus.km_centroid_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_reset("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_converge();
        gaps = 1'b0;
        load_scn1();
        run(4, 1'b0);
        checks++;
        if (res_cyc[0] != 188) begin
            errors++;
            $display("FAIL conv_cycles: got %0d required 188", res_cyc[0]);
        end
        checks++;
        if (res_cent[0] !== {8'd11, 8'd11, 8'd1, 8'd1}) begin
            errors++;
            $display("FAIL conv_centroids: got %h required 0b0b0101", res_cent[0]);
        end
        checks++;
        if (res_iter[0] != 2 || res_conv[0] != 1) begin
            errors++;
            $display("FAIL conv_status: got iter=%0d conv=%0d required iter=2 conv=1", res_iter[0], res_conv[0]);
        end
        checks++;
        if (g_inst[0].cv_cnt != 3 || g_inst[0].en_cnt != 8) begin
            errors++;
            $display("FAIL conv_pulses: got cv=%0d en=%0d required cv=3 en=8", g_inst[0].cv_cnt, g_inst[0].en_cnt);
        end
        checks++;
        if (res_cyc[1] != 95 || res_iter[1] != 1 || res_conv[1] != 0) begin
            errors++;
            $display("FAIL iter_cap: got cyc=%0d iter=%0d conv=%0d required cyc=95 iter=1 conv=0",
                     res_cyc[1], res_iter[1], res_conv[1]);
        end
        checks++;
        if (res_cent[1] !== {8'd11, 8'd11, 8'd1, 8'd1} || g_inst[1].cv_cnt != 2) begin
            errors++;
            $display("FAIL iter_cap_centroids: got %h cv=%0d required 0b0b0101 cv=2", res_cent[1], g_inst[1].cv_cnt);
        end
    endtask

    task automatic test_empty_cluster();
        gaps = 1'b0;
        init_c = {8'd200, 8'd200, 8'd0, 8'd0};
        pts[0] = {8'd1, 8'd1};
        pts[1] = {8'd3, 8'd3};
        np = 2;
        run(2, 1'b0);
        checks++;
        if (res_cent[0] !== {8'd200, 8'd200, 8'd2, 8'd2}) begin
            errors++;
            $display("FAIL empty_centroids: got %h required c8c80202", res_cent[0]);
        end
        checks++;
        if (res_iter[0] != 2 || res_conv[0] != 1 || res_cyc[0] != 100) begin
            errors++;
            $display("FAIL empty_status: got iter=%0d conv=%0d cyc=%0d required iter=2 conv=1 cyc=100",
                     res_iter[0], res_conv[0], res_cyc[0]);
        end
        checks++;
        if (res_cyc[1] != 51 || res_conv[1] != 0) begin
            errors++;
            $display("FAIL empty_cap: got cyc=%0d conv=%0d required cyc=51 conv=0", res_cyc[1], res_conv[1]);
        end
    endtask

    task automatic test_zero_points();
        gaps = 1'b0;
        load_scn1();
        np = 0;
        num_points = '0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (g_inst[0].busy !== 1'b1 || g_inst[0].done !== 1'b0) begin
            errors++;
            $display("FAIL zero_load: got busy=%b done=%b required busy=1 done=0", g_inst[0].busy, g_inst[0].done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (g_inst[0].done !== 1'b1 || g_inst[0].conv !== 1'b1 || g_inst[0].iter !== '0) begin
            errors++;
            $display("FAIL zero_done: got done=%b conv=%b iter=%0d required 1 1 0",
                     g_inst[0].done, g_inst[0].conv, g_inst[0].iter);
        end
        @(posedge clk);
        #1;
        checks++;
        if (g_inst[0].busy !== 1'b0 || g_inst[0].en_cnt != 0 ||
            g_inst[0].bus.km_centroid_o !== {8'd12, 8'd12, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL zero_after: got busy=%b en=%0d centroid=%h required 0 0 0c0c0000",
                     g_inst[0].busy, g_inst[0].en_cnt, g_inst[0].bus.km_centroid_o);
        end
    endtask

    task automatic test_back_pressure();
        gaps = 1'b1;
        load_scn1();
        run(4, 1'b1);
        gaps = 1'b0;
        checks++;
        if (res_cent[0] !== {8'd11, 8'd11, 8'd1, 8'd1} || res_iter[0] != 2 || res_conv[0] != 1) begin
            errors++;
            $display("FAIL bp_result: got %h iter=%0d conv=%0d required 0b0b0101 iter=2 conv=1",
                     res_cent[0], res_iter[0], res_conv[0]);
        end
        checks++;
        if (g_inst[0].en_cnt != 8 || g_inst[0].unstable != 0) begin
            errors++;
            $display("FAIL bp_issue: got en=%0d unstable=%0d required en=8 unstable=0",
                     g_inst[0].en_cnt, g_inst[0].unstable);
        end
        checks++;
        if (res_cent[1] !== {8'd11, 8'd11, 8'd1, 8'd1} || res_iter[1] != 1 || res_conv[1] != 0) begin
            errors++;
            $display("FAIL bp_cap: got %h iter=%0d conv=%0d required 0b0b0101 iter=1 conv=0",
                     res_cent[1], res_iter[1], res_conv[1]);
        end
    endtask

    task automatic test_reset_mid_update();
        bit reached = 1'b0;
        gaps = 1'b0;
        load_scn1();
        num_points = CW'(4);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (g_inst[0].en_cnt == 4 && !g_inst[0].bus.km_data_valid_o && g_inst[0].busy) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL rst_reach_update: got no UPDATE entry required within 200 cycles");
        end
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_reset("mid_update_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        run(4, 1'b0);
        checks++;
        if (res_cyc[0] != 188 || res_cent[0] !== {8'd11, 8'd11, 8'd1, 8'd1} ||
            res_iter[0] != 2 || res_conv[0] != 1 || g_inst[0].cv_cnt != 3) begin
            errors++;
            $display("FAIL rerun: got cyc=%0d cent=%h iter=%0d conv=%0d cv=%0d required 188 0b0b0101 2 1 3",
                     res_cyc[0], res_cent[0], res_iter[0], res_conv[0], g_inst[0].cv_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_converge();
        test_empty_cluster();
        test_zero_points();
        test_back_pressure();
        test_reset_mid_update();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
